mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation.
- flush  in  1  abort the in-flight operation.
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  32  operand A, taken from register-file read port 1.
- rs2_data  in  32  operand B, taken from register-file read port 2.
- rd  in  5  destination register index.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle completion pulse.
- wb_en  out  1  register-file write enable.
- wb_addr  out  5  register-file write address.
- wb_data  out  32  register-file write data.

Function
REQ-003 The FSM SHALL have four states: IDLE, CALC, FINISH and DONE.
REQ-004 In IDLE, start=1 SHALL latch funct3, rd and both operands; any operand change afterwards SHALL be ignored.
REQ-005 start asserted while busy=1 SHALL be ignored, with no effect on the in-flight operation.
REQ-006 busy SHALL be 1 in CALC, FINISH and DONE, and 0 in IDLE.
REQ-007 Normal path SHALL be IDLE -> CALC (exactly 32 cycles) -> FINISH -> DONE -> IDLE.
- start sampled at edge N gives wb_en/done high during cycle N+34.
REQ-008 Multiply SHALL use iterative shift-add over the operand magnitudes, producing a 64-bit product.
- FINISH applies two's-complement sign correction.
- Signedness: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
- MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-009 Divide SHALL use radix-2 restoring division over the operand magnitudes.
- Quotient sign = sign(A) XOR sign(B).
- Remainder takes the sign of the dividend.
REQ-010 Divide by zero SHALL skip CALC and return:
- quotient 0xFFFFFFFF.
- remainder = rs1_data.
- Timing: IDLE -> FINISH -> DONE, so wb_en is high at cycle N+2.
REQ-011 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL skip CALC, returning quotient 0x80000000 and remainder 0, with the same latency as REQ-010.
REQ-012 done SHALL pulse for exactly one cycle (in DONE), and wb_data/wb_addr SHALL be valid in that cycle.
REQ-013 wb_en SHALL equal done AND (latched rd != 0).
- Writes to x0 are suppressed, but done still pulses.
REQ-014 wb_data and wb_addr SHALL hold their last values outside DONE.
REQ-015 flush=1 in any state SHALL force IDLE at the next edge, with no wb_en or done pulse.
- flush takes priority over start in the same cycle.
REQ-016 In DONE the FSM SHALL return to IDLE unconditionally; a new start is accepted only from IDLE (back-to-back spacing of at least one idle cycle).

Reset
REQ-017 When rst=1 at a clock edge, the FSM SHALL enter IDLE and busy, done, wb_en, wb_addr and wb_data SHALL be 0.
REQ-018 Reset during CALC SHALL discard the operation with no write-back; rst has priority over flush and start.

Configuration
REQ-019 Macro MDU_FAST_MUL_EN selects the multiply implementation:
- Defined: multiply ops compute a single-cycle 33x33 signed product and go IDLE -> FINISH -> DONE (wb_en at N+2).
- Undefined: multiply follows REQ-007/REQ-008 (N+34).
- Divide behaviour SHALL be identical in both builds.

Structure
REQ-020 Package mdu_pkg SHALL hold:
- the funct3 encoding constants.
- the FSM state typedef.
- the iteration count constant (32).
- the div-by-zero and overflow result constants.
REQ-021 The single radix-2 iteration step (shared shift/subtract-or-add datapath) SHALL be the sub-module mdu_step_core.
- The FSM, sign handling and write-back registers remain in mdu_iter.

Verification
REQ-022 MUL with A=0x00000007, B=0xFFFFFFFD (-3), rd=5 -> wb_en=1, wb_addr=5, wb_data=0xFFFFFFEB at N+34 (N+2 with MDU_FAST_MUL_EN).
REQ-023 MULHU with A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-024 DIV with A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU with B=0 -> 0xFFFFFFFF at N+2; REMU with A=0x1234, B=0 -> 0x1234.
REQ-025 DIV with A=0x80000000, B=0xFFFFFFFF -> 0x80000000 at N+2; REM with the same operands -> 0.
REQ-026 Second start during CALC is ignored and only one done pulse results; flush at N+10 -> no done; rst at N+20 -> all outputs 0 next cycle.
REQ-027 DIVU 100/7 with rd=0 -> done=1, wb_en=0; an immediately following start in the IDLE cycle is accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants and types for the iterative RV32M multiply/divide unit.
//   - funct3 encodings for the eight RV32M operations
//   - FSM state type
//   - iteration count for the radix-2 loop
//   - fixed results for divide-by-zero and signed overflow
package mdu_pkg;

   localparam logic [2:0] Funct3Mul    = 3'b000;
   localparam logic [2:0] Funct3Mulh   = 3'b001;
   localparam logic [2:0] Funct3Mulhsu = 3'b010;
   localparam logic [2:0] Funct3Mulhu  = 3'b011;
   localparam logic [2:0] Funct3Div    = 3'b100;
   localparam logic [2:0] Funct3Divu   = 3'b101;
   localparam logic [2:0] Funct3Rem    = 3'b110;
   localparam logic [2:0] Funct3Remu   = 3'b111;

   localparam int unsigned IterCount = 32;

   localparam logic [31:0] DivZeroQuot = 32'hFFFF_FFFF;
   localparam logic [31:0] OvfQuot     = 32'h8000_0000;
   localparam logic [31:0] OvfRem      = 32'h0000_0000;
   localparam logic [31:0] IntMin      = 32'h8000_0000;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFinish,
      StDone
   } mdu_state_e;

   // funct3[2] separates the divide group from the multiply group.
   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/mdu_step_core.sv
// mdu_step_core: one radix-2 iteration of the shared multiply/divide datapath.
// A single XLEN+1 bit adder serves both operations:
//   multiply (is_div_i=0): shift-add, {hi,lo} := ({hi} + (lo[0] ? b : 0)) : lo  >> 1
//   divide   (is_div_i=1): restoring step on partial remainder hi, dividend/quotient in lo
// Ports:
//   is_div_i  select divide step (1) or multiply step (0)
//   hi_i/lo_i current high/low working registers
//   b_i       multiplicand or divisor magnitude
//   hi_o/lo_o next high/low working registers
module mdu_step_core #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] op_a;
   logic [XLEN:0] op_b;
   logic [XLEN:0] sum;
   logic          cin;
   logic          ge;

   always_comb begin
      if (is_div_i) begin
         // Shift the next dividend bit into the partial remainder, then subtract.
         op_a = {hi_i, lo_i[XLEN-1]};
         op_b = ~{1'b0, b_i};
         cin  = 1'b1;
      end else begin
         op_a = {1'b0, hi_i};
         op_b = lo_i[0] ? {1'b0, b_i} : '0;
         cin  = 1'b0;
      end
      sum = op_a + op_b + {{XLEN{1'b0}}, cin};

      // Partial remainder < divisor, so the difference never exceeds XLEN bits;
      // the top bit is therefore a clean borrow flag.
      ge = ~sum[XLEN];

      if (is_div_i) begin
         hi_o = ge ? sum[XLEN-1:0] : op_a[XLEN-1:0];
         lo_o = {lo_i[XLEN-2:0], ge};
      end else begin
         hi_o = sum[XLEN:1];
         lo_o = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit with register-file write-back.
// Optional build macro: MDU_FAST_MUL_EN (single-cycle 33x33 signed multiply).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, flush       begin operation (IDLE only) / abort in-flight operation
//   funct3             RV32M operation select
//   rs1_data, rs2_data operands A and B
//   rd                 destination register index
//   busy, done         operation in flight / one-cycle completion pulse
//   wb_en, wb_addr, wb_data  register-file write port (held outside DONE)
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd,
   output logic            busy,
   output logic            done,
   output logic            wb_en,
   output logic [4:0]      wb_addr,
   output logic [XLEN-1:0] wb_data
);

   localparam int unsigned CntW = $clog2(IterCount);
   localparam logic [CntW-1:0] CntLast = CntW'(IterCount - 1);

   mdu_state_e state_q, state_d;

   logic [CntW-1:0] cnt_q;
   logic [XLEN-1:0] hi_q, lo_q, b_q;
   logic            is_div_q, is_rem_q, mul_hi_q, neg_q, rem_neg_q;
   logic [4:0]      rd_q, wb_addr_q;
   logic [XLEN-1:0] wb_data_q;

   // Operand decode, only meaningful while accepting in IDLE.
   logic            op_div, a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, skip_calc, accept;

   always_comb begin
      op_div   = is_div_op(funct3);
      a_signed = op_div ? ~funct3[0] : (funct3 == Funct3Mulh || funct3 == Funct3Mulhsu);
      b_signed = op_div ? ~funct3[0] : (funct3 == Funct3Mulh);
      a_neg    = a_signed & rs1_data[XLEN-1];
      b_neg    = b_signed & rs2_data[XLEN-1];
      a_mag    = a_neg ? -rs1_data : rs1_data;
      b_mag    = b_neg ? -rs2_data : rs2_data;
      div_zero = op_div & (rs2_data == '0);
      div_ovf  = op_div & ~funct3[0] & (rs1_data == IntMin) & (rs2_data == '1);
`ifdef MDU_FAST_MUL_EN
      skip_calc = div_zero | div_ovf | ~op_div;
`else
      skip_calc = div_zero | div_ovf;
`endif
      accept = (state_q == StIdle) & start & ~flush;
   end

`ifdef MDU_FAST_MUL_EN
   // Sign-extended 33-bit operands make one signed multiplier cover all four ops.
   logic signed [XLEN:0]     fast_a, fast_b;
   logic signed [2*XLEN+1:0] fast_prod;
   always_comb begin
      fast_a    = {a_signed & rs1_data[XLEN-1], rs1_data};
      fast_b    = {b_signed & rs2_data[XLEN-1], rs2_data};
      fast_prod = fast_a * fast_b;
   end
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:   if (start) state_d = skip_calc ? StFinish : StCalc;
            StCalc:   if (cnt_q == CntLast) state_d = StFinish;
            StFinish: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy  = (state_q != StIdle);
      done  = (state_q == StDone);
      wb_en = done & (wb_addr_q != 5'd0);
   end

   // ---------------- iteration datapath ----------------
   logic [XLEN-1:0] step_hi, step_lo;

   mdu_step_core #(
      .XLEN (XLEN)
   ) u_step_core (
      .is_div_i (is_div_q),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .b_i      (b_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         is_div_q  <= 1'b0;
         is_rem_q  <= 1'b0;
         mul_hi_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         rd_q      <= '0;
      end else if (accept) begin
         cnt_q     <= '0;
         b_q       <= b_mag;
         is_div_q  <= op_div;
         is_rem_q  <= funct3[1];
         mul_hi_q  <= (funct3[1:0] != 2'b00);
         rd_q      <= rd;
         rem_neg_q <= 1'b0;
         neg_q     <= a_neg ^ b_neg;
         hi_q      <= '0;
         lo_q      <= a_mag;
         if (div_zero) begin
            hi_q  <= rs1_data;
            lo_q  <= DivZeroQuot;
            neg_q <= 1'b0;
         end else if (div_ovf) begin
            hi_q  <= OvfRem;
            lo_q  <= OvfQuot;
            neg_q <= 1'b0;
         end else if (op_div) begin
            rem_neg_q <= a_neg;
`ifdef MDU_FAST_MUL_EN
         end else begin
            hi_q  <= fast_prod[2*XLEN-1:XLEN];
            lo_q  <= fast_prod[XLEN-1:0];
            neg_q <= 1'b0;
`endif
         end
      end else if (state_q == StCalc) begin
         cnt_q <= cnt_q + 1'b1;
         hi_q  <= step_hi;
         lo_q  <= step_lo;
      end
   end

   // ---------------- sign correction and write-back ----------------
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quot, rem, result;

   always_comb begin
      prod     = {hi_q, lo_q};
      prod_fix = neg_q ? -prod : prod;
      quot     = neg_q ? -lo_q : lo_q;
      rem      = rem_neg_q ? -hi_q : hi_q;
      if (is_div_q) begin
         result = is_rem_q ? rem : quot;
      end else begin
         result = mul_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
      end
   end

   // Write-back registers load only on FINISH->DONE so they hold everywhere else.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else if ((state_q == StFinish) && !flush) begin
         wb_addr_q <= rd_q;
         wb_data_q <= result;
      end
   end

   assign wb_addr = wb_addr_q;
   assign wb_data = wb_data_q;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
   import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
   localparam int MulLat = 2;
`else
   localparam int MulLat = 34;
`endif
   localparam int DivLat = 34;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd;
   logic        busy, done, wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mdu_iter #(
      .XLEN (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .flush    (flush),
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd       (rd),
      .busy     (busy),
      .done     (done),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called 1 time unit after a rising edge in an IDLE cycle; start is sampled at the
   // next edge (edge N). Operands are then scrambled to show they were latched.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
      funct3 = f; rs1_data = a; rs2_data = b; rd = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; funct3 = ~f; rd = ~r;
   endtask

   // lat counts from edge N: done is visible in cycle N+lat (after edge N+lat-1).
   task automatic expect_wb(input string tag, input int lat, input logic [31:0] data,
                            input logic [4:0] r);
      repeat (lat - 2) @(posedge clk);
      #1;
      chk({tag, ".pre_done"}, {31'd0, done}, 32'd0);
      chk({tag, ".pre_busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      chk({tag, ".done"}, {31'd0, done}, 32'd1);
      chk({tag, ".wb_en"}, {31'd0, wb_en}, {31'd0, (r != 5'd0)});
      chk({tag, ".wb_addr"}, {27'd0, wb_addr}, {27'd0, r});
      chk({tag, ".wb_data"}, wb_data, data);
      @(posedge clk); #1;
      chk({tag, ".post_done"}, {31'd0, done}, 32'd0);
      chk({tag, ".post_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, ".hold_data"}, wb_data, data);
   endtask

   task automatic no_done(input string tag, input int cycles);
      int c = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (done || wb_en) c++;
      end
      chk(tag, 32'(c), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0;
      funct3 = '0; rs1_data = '0; rs2_data = '0; rd = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.busy", {31'd0, busy}, 32'd0);
      chk("reset.done", {31'd0, done}, 32'd0);
      chk("reset.wb_en", {31'd0, wb_en}, 32'd0);
      chk("reset.wb_addr", {27'd0, wb_addr}, 32'd0);
      chk("reset.wb_data", wb_data, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Multiply group
      issue(Funct3Mul, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
      expect_wb("mul_7x-3", MulLat, 32'hFFFF_FFEB, 5'd5);
      issue(Funct3Mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
      expect_wb("mulhu_max", MulLat, 32'hFFFF_FFFE, 5'd6);
      issue(Funct3Mulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
      expect_wb("mulh_m1", MulLat, 32'h0000_0000, 5'd7);
      issue(Funct3Mulhsu, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8);
      expect_wb("mulhsu", MulLat, 32'hFFFF_FFFF, 5'd8);

      // Divide group
      issue(Funct3Div, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9);
      expect_wb("div_-7/2", DivLat, 32'hFFFF_FFFD, 5'd9);
      issue(Funct3Rem, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10);
      expect_wb("rem_-7/2", DivLat, 32'hFFFF_FFFF, 5'd10);
      issue(Funct3Divu, 32'h0000_DEAD, 32'h0000_0000, 5'd11);
      expect_wb("divu_by0", 2, 32'hFFFF_FFFF, 5'd11);
      issue(Funct3Remu, 32'h0000_1234, 32'h0000_0000, 5'd12);
      expect_wb("remu_by0", 2, 32'h0000_1234, 5'd12);
      issue(Funct3Div, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
      expect_wb("div_ovf", 2, 32'h8000_0000, 5'd13);
      issue(Funct3Rem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
      expect_wb("rem_ovf", 2, 32'h0000_0000, 5'd14);

      // rd=0 suppresses the write; the very next IDLE cycle accepts a new start
      issue(Funct3Divu, 32'd100, 32'd7, 5'd0);
      expect_wb("divu_x0", DivLat, 32'd14, 5'd0);
      issue(Funct3Remu, 32'd100, 32'd7, 5'd3);
      expect_wb("remu_b2b", DivLat, 32'd2, 5'd3);

      // Second start while busy is ignored
      issue(Funct3Divu, 32'd1000, 32'd10, 5'd15);
      repeat (4) @(posedge clk);
      #1;
      funct3 = Funct3Mul; rs1_data = 32'd3; rs2_data = 32'd3; rd = 5'd16; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      expect_wb("busy_start", DivLat - 5, 32'd100, 5'd15);
      no_done("busy_start.extra_done", 40);

      // Flush at N+10 aborts without a done pulse
      issue(Funct3Div, 32'd100, 32'd5, 5'd17);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush.busy", {31'd0, busy}, 32'd0);
      no_done("flush.no_done", 40);
      chk("flush.wb_data_held", wb_data, 32'd100);

      // Flush beats start in the same cycle
      funct3 = Funct3Divu; rs1_data = 32'd1; rs2_data = 32'd0; rd = 5'd19;
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_vs_start.busy", {31'd0, busy}, 32'd0);
      no_done("flush_vs_start.no_done", 6);

      // Reset at N+20 clears everything and discards the operation
      issue(Funct3Div, 32'd100, 32'd5, 5'd18);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1; flush = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; flush = 1'b0; start = 1'b0;
      chk("rst_calc.busy", {31'd0, busy}, 32'd0);
      chk("rst_calc.done", {31'd0, done}, 32'd0);
      chk("rst_calc.wb_en", {31'd0, wb_en}, 32'd0);
      chk("rst_calc.wb_addr", {27'd0, wb_addr}, 32'd0);
      chk("rst_calc.wb_data", wb_data, 32'd0);
      no_done("rst_calc.no_done", 40);

      // Unit is usable again after reset
      issue(Funct3Mulhu, 32'h0001_0000, 32'h0001_0000, 5'd1);
      expect_wb("mulhu_after_rst", MulLat, 32'h0000_0001, 5'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
